// File: rtl/spi_bus_arb_pkg.sv
// Shared definitions for the flash SPI pin arbiter: state encoding and port identifiers.
package spi_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_GUARD = 2'd3
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/spi_bus_arb.sv
// Two-master arbiter for the shared flash SPI pads (port 0 = SoC SPI core, port 1 = LED/button engine).
// Grants one owner at a time, inserts idle guard cycles between owners and asks port 1 to yield on long waits.
module spi_bus_arb
    import spi_bus_arb_pkg::*;
#(
    parameter int GUARD_CYCLES = 4,
    parameter int MAX_HOLD     = 255,
    parameter int CW           = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1,
    output logic o_preempt1,
    input  logic i_m0_mosi_o,
    input  logic i_m0_mosi_oe,
    input  logic i_m0_clk_o,
    input  logic i_m0_clk_oe,
    input  logic i_m0_csn_o,
    input  logic i_m1_mosi_o,
    input  logic i_m1_mosi_oe,
    input  logic i_m1_clk_o,
    input  logic i_m1_clk_oe,
    input  logic i_m1_csn_o,
    output logic o_spi_mosi_o,
    output logic o_spi_mosi_oe,
    output logic o_spi_clk_o,
    output logic o_spi_clk_oe,
    output logic o_spi_csn_o,
    input  logic i_spi_miso_i,
    output logic o_m0_miso_i,
    output logic o_m1_miso_i
);

    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_last;
    logic          w_last_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= PORT1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // The single counter measures the guard gap in GUARD and port 0's waiting time in OWN1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (i_req0 && i_req1) begin
                    w_state_nxt = (r_last == PORT1) ? ST_OWN0 : ST_OWN1;
                end else if (i_req0) begin
                    w_state_nxt = ST_OWN0;
                end else if (i_req1) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!i_req0) begin
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = PORT0;
                end
            end
            ST_OWN1: begin
                if (!i_req1) begin
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = PORT1;
                end else if (i_req0 && (r_cnt != HOLD_LIMIT)) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_GUARD: begin
                if (r_cnt == GUARD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_gnt0     = (r_state == ST_OWN0);
    assign o_gnt1     = (r_state == ST_OWN1);
    assign o_preempt1 = (r_state == ST_OWN1) && (r_cnt == HOLD_LIMIT);

    // Pads default to idle (deselected, undriven) unless a port currently owns the bus.
    always_comb begin
        o_spi_mosi_o  = 1'b0;
        o_spi_mosi_oe = 1'b0;
        o_spi_clk_o   = 1'b0;
        o_spi_clk_oe  = 1'b0;
        o_spi_csn_o   = 1'b1;
        if (r_state == ST_OWN0) begin
            o_spi_mosi_o  = i_m0_mosi_o;
            o_spi_mosi_oe = i_m0_mosi_oe;
            o_spi_clk_o   = i_m0_clk_o;
            o_spi_clk_oe  = i_m0_clk_oe;
            o_spi_csn_o   = i_m0_csn_o;
        end else if (r_state == ST_OWN1) begin
            o_spi_mosi_o  = i_m1_mosi_o;
            o_spi_mosi_oe = i_m1_mosi_oe;
            o_spi_clk_o   = i_m1_clk_o;
            o_spi_clk_oe  = i_m1_clk_oe;
            o_spi_csn_o   = i_m1_csn_o;
        end
    end

    assign o_m0_miso_i = i_spi_miso_i;
    assign o_m1_miso_i = i_spi_miso_i;

endmodule

// File: tb/tb_spi_bus_arb.sv
// Self-checking bench for spi_bus_arb: directed scenarios with literal expectations plus a
// cycle-level ownership model compared against the DUT on every clock.
module tb_spi_bus_arb;

    localparam int GUARD    = 4;
    localparam int MAX_HOLD = 255;

    logic clk = 1'b0;
    logic rstN;
    logic req0, req1;
    logic gnt0, gnt1, preempt1;
    logic m0MosiO, m0MosiOe, m0ClkO, m0ClkOe, m0CsnO;
    logic m1MosiO, m1MosiOe, m1ClkO, m1ClkOe, m1CsnO;
    logic spiMosiO, spiMosiOe, spiClkO, spiClkOe, spiCsnO;
    logic spiMisoI, m0MisoI, m1MisoI;

    int checks = 0;
    int errors = 0;

    int mOwner = -1;
    int mGuard = 0;
    int mLast  = 1;
    int mHold  = 0;
    bit modelValid = 1'b0;

    always #5 clk = ~clk;

    spi_bus_arb #(.GUARD_CYCLES(GUARD), .MAX_HOLD(MAX_HOLD), .CW(8)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_req0(req0), .i_req1(req1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_preempt1(preempt1),
        .i_m0_mosi_o(m0MosiO), .i_m0_mosi_oe(m0MosiOe), .i_m0_clk_o(m0ClkO),
        .i_m0_clk_oe(m0ClkOe), .i_m0_csn_o(m0CsnO),
        .i_m1_mosi_o(m1MosiO), .i_m1_mosi_oe(m1MosiOe), .i_m1_clk_o(m1ClkO),
        .i_m1_clk_oe(m1ClkOe), .i_m1_csn_o(m1CsnO),
        .o_spi_mosi_o(spiMosiO), .o_spi_mosi_oe(spiMosiOe), .o_spi_clk_o(spiClkO),
        .o_spi_clk_oe(spiClkOe), .o_spi_csn_o(spiCsnO),
        .i_spi_miso_i(spiMisoI), .o_m0_miso_i(m0MisoI), .o_m1_miso_i(m1MisoI)
    );

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic r1);
        req0 = r0;
        req1 = r1;
    endtask

    // Ownership model: who holds the bus, how much guard time remains, how long port 0 has waited.
    always @(posedge clk) begin
        if (!rstN) begin
            mOwner = -1;
            mGuard = 0;
            mLast = 1;
            mHold = 0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (mOwner == 0) begin
                if (!req0) begin
                    mOwner = -1;
                    mGuard = GUARD;
                    mLast = 0;
                end
            end else if (mOwner == 1) begin
                if (!req1) begin
                    mOwner = -1;
                    mGuard = GUARD;
                    mLast = 1;
                end else if (req0 && mHold < MAX_HOLD) begin
                    mHold++;
                end
            end else if (mGuard > 0) begin
                mGuard--;
            end else if (req0 || req1) begin
                mOwner = (req0 && req1) ? ((mLast == 1) ? 0 : 1) : (req0 ? 0 : 1);
                mHold = 0;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("gnt0", gnt0, mOwner == 0);
            checkOutput("gnt1", gnt1, mOwner == 1);
            checkOutput("gntExclusive", gnt0 & gnt1, 1'b0);
            checkOutput("preempt1", preempt1, (mOwner == 1) && (mHold == MAX_HOLD));
            checkOutput("m0Miso", m0MisoI, spiMisoI);
            checkOutput("m1Miso", m1MisoI, spiMisoI);
            if (mOwner < 0) begin
                checkOutput("idleCsn", spiCsnO, 1'b1);
                checkOutput("idleClkOe", spiClkOe, 1'b0);
                checkOutput("idleMosiOe", spiMosiOe, 1'b0);
            end else begin
                checkOutput("padCsn", spiCsnO, (mOwner == 0) ? m0CsnO : m1CsnO);
                checkOutput("padClk", spiClkO, (mOwner == 0) ? m0ClkO : m1ClkO);
                checkOutput("padClkOe", spiClkOe, (mOwner == 0) ? m0ClkOe : m1ClkOe);
                checkOutput("padMosi", spiMosiO, (mOwner == 0) ? m0MosiO : m1MosiO);
                checkOutput("padMosiOe", spiMosiOe, (mOwner == 0) ? m0MosiOe : m1MosiOe);
            end
        end
    end

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0);
        {m0MosiO, m0MosiOe, m0ClkO, m0ClkOe} = '0;
        {m1MosiO, m1MosiOe, m1ClkO, m1ClkOe} = '0;
        m0CsnO = 1'b1;
        m1CsnO = 1'b1;
        spiMisoI = 1'b0;
        tick();
        tick();
        rstN = 1'b1;
        checkOutput("rstGnt0", gnt0, 1'b0);
        checkOutput("rstGnt1", gnt1, 1'b0);
        checkOutput("rstPreempt", preempt1, 1'b0);
        checkOutput("rstCsn", spiCsnO, 1'b1);
        checkOutput("rstClkOe", spiClkOe, 1'b0);

        // Port 1 alone: grant after one cycle, pads track m1.
        applyStimulus(1'b0, 1'b1);
        {m1MosiO, m1MosiOe, m1ClkO, m1ClkOe, m1CsnO} = 5'b11110;
        checkOutput("t1GntLatency", gnt1, 1'b0);
        tick();
        checkOutput("t1Gnt1", gnt1, 1'b1);
        checkOutput("t1Clk", spiClkO, 1'b1);
        checkOutput("t1Csn", spiCsnO, 1'b0);
        m1ClkO = 1'b0;
        #1;
        checkOutput("t1ClkTrack", spiClkO, 1'b0);
        applyStimulus(1'b0, 1'b0);
        tick();
        // Re-request in guard while m1 still drives its pins: held off for exactly 4 cycles.
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < GUARD; i++) begin
            checkOutput("t1GuardGnt", gnt1, 1'b0);
            checkOutput("t6GuardCsn", spiCsnO, 1'b1);
            checkOutput("t6GuardClkOe", spiClkOe, 1'b0);
            tick();
        end
        checkOutput("t1IdleGnt", gnt1, 1'b0);
        tick();
        checkOutput("t1Regrant", gnt1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        {m1MosiO, m1MosiOe, m1ClkO, m1ClkOe, m1CsnO} = 5'b00001;
        repeat (GUARD + 1) tick();

        // Simultaneous requests after reset: port 0 first, then port 1.
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("t2Gnt0First", gnt0, 1'b1);
        checkOutput("t2Gnt1Low", gnt1, 1'b0);
        m0CsnO = 1'b0;
        #1;
        checkOutput("t2CsnTrack", spiCsnO, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1);
        m0CsnO = 1'b1;
        tick();
        checkOutput("t2GuardGnt0", gnt0, 1'b0);
        repeat (GUARD) tick();
        checkOutput("t2IdleGnt1", gnt1, 1'b0);
        tick();
        checkOutput("t2Alternate", gnt1, 1'b1);

        // Port 0 waits behind port 1: preempt at t0+255, grant at t0+306.
        applyStimulus(1'b1, 1'b1);
        repeat (254) tick();
        checkOutput("t3PreemptEarly", preempt1, 1'b0);
        tick();
        checkOutput("t3Preempt", preempt1, 1'b1);
        repeat (45) tick();
        checkOutput("t3PreemptHeld", preempt1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 301; i <= 305; i++) begin
            tick();
            checkOutput("t3WaitGnt0", gnt0, 1'b0);
            checkOutput("t3PreemptOff", preempt1, 1'b0);
        end
        tick();
        checkOutput("t3Gnt0", gnt0, 1'b1);

        // Reset mid-transfer while port 0 drives the pads.
        {m0MosiOe, m0ClkOe, m0CsnO} = 3'b110;
        #1;
        checkOutput("t5CsnBefore", spiCsnO, 1'b0);
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0);
        tick();
        rstN = 1'b1;
        checkOutput("t5Gnt0", gnt0, 1'b0);
        checkOutput("t5Csn", spiCsnO, 1'b1);
        checkOutput("t5ClkOe", spiClkOe, 1'b0);
        checkOutput("t5MosiOe", spiMosiOe, 1'b0);
        checkOutput("t5Preempt", preempt1, 1'b0);
        {m0MosiOe, m0ClkOe, m0CsnO} = 3'b001;

        // Idle bus: single-cycle grant latency.
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("t4Latency", gnt0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        repeat (GUARD + 1) tick();

        // Random traffic; the model compare and exclusivity check run every cycle.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) req0 = ~req0;
            if ($urandom_range(7) == 0) req1 = ~req1;
            rstN = ($urandom_range(499) != 0);
            {m0MosiO, m0MosiOe, m0ClkO, m0ClkOe, m0CsnO} = 5'($urandom);
            {m1MosiO, m1MosiOe, m1ClkO, m1ClkOe, m1CsnO} = 5'($urandom);
            spiMisoI = 1'($urandom);
            tick();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
